// File: rtl/syst_ws_ctrl.sv
// syst_ws_ctrl
// Sequencing controller for a STR x COL weight-stationary systolic array.
// It loads a row-major weight stream into shadow registers, commits them to
// the array in one cycle, and skews X vectors column by column into the top
// row of the array. Validity and last markers travel through a shadow
// pipeline. The per-row partial sums coming back are deskewed and returned
// as aligned Y vectors.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   start_i, reuse_w_i    job start (IDLE only); reuse_w_i skips the weight load
//   busy_o, done_o        not-IDLE flag; one-cycle end-of-job pulse
//   w_data_i/valid/ready  weight word stream, index i*COL+j
//   x_data_i/valid/last/ready  X vector stream, column j at [j*X_WIDTH +: X_WIDTH]
//   arr_weight_o, arr_valid_w_o  weights and weight strobes to the array
//   arr_x_o, arr_valid_o  skewed top-row activations and valids to the array
//   arr_y_i               per-row results from the array
//   y_data_o/valid/last   aligned results, row i at [i*Y_WIDTH +: Y_WIDTH]
module syst_ws_ctrl #(
    parameter int STR     = 4,
    parameter int COL     = 4,
    parameter int W_WIDTH = 8,
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 20
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    start_i,
    input  logic                                    reuse_w_i,
    output logic                                    busy_o,
    output logic                                    done_o,
    input  logic [W_WIDTH-1:0]                      w_data_i,
    input  logic                                    w_valid_i,
    output logic                                    w_ready_o,
    input  logic [COL*X_WIDTH-1:0]                  x_data_i,
    input  logic                                    x_valid_i,
    input  logic                                    x_last_i,
    output logic                                    x_ready_o,
    output logic [STR-1:0][COL-1:0][W_WIDTH-1:0]    arr_weight_o,
    output logic [STR-1:0][COL-1:0]                 arr_valid_w_o,
    output logic [COL-1:0][X_WIDTH-1:0]             arr_x_o,
    output logic [COL-1:0]                          arr_valid_o,
    input  logic [STR-1:0][Y_WIDTH-1:0]             arr_y_i,
    output logic [STR*Y_WIDTH-1:0]                  y_data_o,
    output logic                                    y_valid_o,
    output logic                                    y_last_o
);

    localparam int NW     = STR * COL;
    localparam int WCNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int DEPTH  = COL + STR + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NW - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        COMMIT = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                                 state_r;
    state_t                                 state_next_s;
    logic                                   w_hs_s;
    logic                                   x_hs_s;
    logic [WCNT_W-1:0]                      wcnt_r;
    logic                                   busy_r;
    logic                                   done_r;
    logic                                   w_ready_r;
    logic                                   x_ready_r;
    logic [STR-1:0][COL-1:0][W_WIDTH-1:0]   weight_r;
    logic [STR-1:0][COL-1:0]                valid_w_r;
    logic [DEPTH-1:0]                       sh_valid_r;
    logic [DEPTH-1:0]                       sh_last_r;
    logic [COL*X_WIDTH-1:0]                 sk_in_s;
    logic [STR-1:0][Y_WIDTH-1:0]            row_al_s;
    logic [STR-1:0][Y_WIDTH-1:0]            y_data_r;

    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign w_ready_o     = w_ready_r;
    assign x_ready_o     = x_ready_r;
    assign arr_weight_o  = weight_r;
    assign arr_valid_w_o = valid_w_r;
    assign y_valid_o     = sh_valid_r[DEPTH-1];
    assign y_last_o      = sh_last_r[DEPTH-1];
    assign y_data_o      = y_data_r;

    // Non-accepted cycles feed zero data so bubbles never carry stale values.
    assign sk_in_s = x_hs_s ? x_data_i : '0;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and handshake qualification.
    always_comb begin
        state_next_s = state_r;
        w_hs_s       = 1'b0;
        x_hs_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (reuse_w_i) begin
                        state_next_s = STREAM;
                    end else begin
                        state_next_s = LOAD_W;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_W: begin
                w_hs_s = w_valid_i && w_ready_r;
                if (w_hs_s && (wcnt_r == WCNT_LAST)) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = LOAD_W;
                end
            end
            COMMIT: begin
                state_next_s = STREAM;
            end
            STREAM: begin
                x_hs_s = x_valid_i && x_ready_r;
                if (x_hs_s && x_last_i) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = STREAM;
                end
            end
            DRAIN: begin
                // y_last_o is registered, so leaving here lines up with done_o.
                if (y_last_o) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Registered control outputs and the weight word counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            w_ready_r <= 1'b0;
            x_ready_r <= 1'b0;
            valid_w_r <= '0;
            wcnt_r    <= '0;
        end else begin
            busy_r    <= (state_next_s != IDLE);
            w_ready_r <= (state_next_s == LOAD_W);
            x_ready_r <= (state_next_s == STREAM);
            valid_w_r <= {NW{(state_next_s == COMMIT)}};
            // One cycle ahead of y_last_o so both assert together.
            done_r    <= (state_r == DRAIN) && sh_valid_r[DEPTH-2] && sh_last_r[DEPTH-2];
            if (state_r != LOAD_W) begin
                wcnt_r <= '0;
            end else if (w_hs_s) begin
                wcnt_r <= (wcnt_r == WCNT_LAST) ? '0 : wcnt_r + WCNT_W'(1);
            end
        end
    end

    // Shadow weights, which also drive the array weight bus directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            weight_r <= '0;
        end else begin
            for (int i = 0; i < STR; i++) begin
                for (int j = 0; j < COL; j++) begin
                    if (w_hs_s && (wcnt_r == WCNT_W'(i * COL + j))) begin
                        weight_r[i][j] <= w_data_i;
                    end
                end
            end
        end
    end

    // Valid/last shadow pipeline spanning skew, array and deskew latency.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_valid_r <= '0;
            sh_last_r  <= '0;
        end else begin
            sh_valid_r <= {sh_valid_r[DEPTH-2:0], x_hs_s};
            sh_last_r  <= {sh_last_r[DEPTH-2:0], x_hs_s && x_last_i};
        end
    end

    // Input skew: column j sees the vector j cycles after column 0.
    for (genvar gj = 0; gj < COL; gj++) begin : g_skew
        logic [gj:0][X_WIDTH-1:0] d_r;
        logic [gj:0]              v_r;

        // Column delay line of 1+gj stages.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                d_r <= '0;
                v_r <= '0;
            end else begin
                d_r[0] <= sk_in_s[gj*X_WIDTH +: X_WIDTH];
                v_r[0] <= x_hs_s;
                for (int k = 1; k <= gj; k++) begin
                    d_r[k] <= d_r[k-1];
                    v_r[k] <= v_r[k-1];
                end
            end
        end

        assign arr_x_o[gj]     = d_r[gj];
        assign arr_valid_o[gj] = v_r[gj];
    end

    // Output deskew: row i waits STR-1-i cycles so all rows line up.
    for (genvar gi = 0; gi < STR; gi++) begin : g_deskew
        if (gi < STR - 1) begin : g_dly
            localparam int N = STR - 1 - gi;
            logic [N-1:0][Y_WIDTH-1:0] d_r;

            // Row delay line of N stages.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    d_r <= '0;
                end else begin
                    d_r[0] <= arr_y_i[gi];
                    for (int k = 1; k < N; k++) begin
                        d_r[k] <= d_r[k-1];
                    end
                end
            end

            assign row_al_s[gi] = d_r[N-1];
        end else begin : g_pass
            assign row_al_s[gi] = arr_y_i[gi];
        end
    end

    // Aligned result register; forced to zero for non-valid slots.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_data_r <= '0;
        end else if (sh_valid_r[DEPTH-2]) begin
            y_data_r <= row_al_s;
        end else begin
            y_data_r <= '0;
        end
    end

endmodule

// File: tb/tb_syst_ws_ctrl.sv
module tb_syst_ws_ctrl;

    localparam int STR     = 4;
    localparam int COL     = 4;
    localparam int W_WIDTH = 8;
    localparam int X_WIDTH = 8;
    localparam int Y_WIDTH = 20;
    localparam int LAT     = COL + STR + 1;

    typedef struct {
        logic                           valid;
        logic                           last;
        logic [COL-1:0][X_WIDTH-1:0]    x;
        logic [STR-1:0][Y_WIDTH-1:0]    y;
    } vec_t;

    logic                                   clk;
    logic                                   rst;
    logic                                   start;
    logic                                   reuse_w;
    logic                                   busy;
    logic                                   done;
    logic [W_WIDTH-1:0]                     w_data;
    logic                                   w_valid;
    logic                                   w_ready;
    logic [COL*X_WIDTH-1:0]                 x_data;
    logic                                   x_valid;
    logic                                   x_last;
    logic                                   x_ready;
    logic [STR-1:0][COL-1:0][W_WIDTH-1:0]   arr_weight;
    logic [STR-1:0][COL-1:0]                arr_valid_w;
    logic [COL-1:0][X_WIDTH-1:0]            arr_x;
    logic [COL-1:0]                         arr_valid;
    logic [STR-1:0][Y_WIDTH-1:0]            arr_y;
    logic [STR*Y_WIDTH-1:0]                 y_data;
    logic                                   y_valid;
    logic                                   y_last;

    int   n_checks;
    int   n_err;
    vec_t tab [10];

    syst_ws_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .reuse_w_i     (reuse_w),
        .busy_o        (busy),
        .done_o        (done),
        .w_data_i      (w_data),
        .w_valid_i     (w_valid),
        .w_ready_o     (w_ready),
        .x_data_i      (x_data),
        .x_valid_i     (x_valid),
        .x_last_i      (x_last),
        .x_ready_o     (x_ready),
        .arr_weight_o  (arr_weight),
        .arr_valid_w_o (arr_valid_w),
        .arr_x_o       (arr_x),
        .arr_valid_o   (arr_valid),
        .arr_y_i       (arr_y),
        .y_data_o      (y_data),
        .y_valid_o     (y_valid),
        .y_last_o      (y_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural weight-stationary array: x flows down columns, sums flow along rows.
    logic [W_WIDTH-1:0] wm [STR][COL];
    logic [X_WIDTH-1:0] xr [STR][COL];
    logic [Y_WIDTH-1:0] ps [STR][COL];

    function automatic logic [X_WIDTH-1:0] xin_f(input int i, input int j);
        if (i == 0) return arr_x[j];
        else return xr[i-1][j];
    endfunction

    function automatic logic [Y_WIDTH-1:0] pin_f(input int i, input int j);
        if (j == 0) return '0;
        else return ps[i][j-1];
    endfunction

    // Array register update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STR; i++) begin
            for (int j = 0; j < COL; j++) begin
                if (rst) begin
                    wm[i][j] <= '0;
                    xr[i][j] <= '0;
                    ps[i][j] <= '0;
                end else begin
                    if (arr_valid_w[i][j]) wm[i][j] <= arr_weight[i][j];
                    xr[i][j] <= xin_f(i, j);
                    ps[i][j] <= pin_f(i, j) + Y_WIDTH'(wm[i][j]) * Y_WIDTH'(xin_f(i, j));
                end
            end
        end
    end

    // Row outputs of the array.
    always_comb begin
        for (int i = 0; i < STR; i++) arr_y[i] = ps[i][COL-1];
    end

    function automatic vec_t mk(input logic v, input logic l,
                                input int x0, input int x1, input int x2, input int x3,
                                input int y0, input int y1, input int y2, input int y3);
        vec_t r;
        r.valid = v;
        r.last  = l;
        r.x[0] = X_WIDTH'(x0); r.x[1] = X_WIDTH'(x1); r.x[2] = X_WIDTH'(x2); r.x[3] = X_WIDTH'(x3);
        r.y[0] = Y_WIDTH'(y0); r.y[1] = Y_WIDTH'(y1); r.y[2] = Y_WIDTH'(y2); r.y[3] = Y_WIDTH'(y3);
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, done, w_ready, x_ready, y_valid, y_last}, 6'b0);
        chk({tag, "_ydata"}, y_data, 80'b0);
        chk({tag, "_arr_x"}, {arr_x, arr_valid}, 36'b0);
        chk({tag, "_arr_w"}, {arr_weight, arr_valid_w}, 144'b0);
    endtask

    task automatic start_job(input logic ru);
        start   = 1'b1;
        reuse_w = ru;
        step();
        start   = 1'b0;
        reuse_w = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_w_ready", w_ready, !ru);
        chk("start_x_ready", x_ready, ru);
    endtask

    task automatic load_w(input logic [15:0][7:0] w, input logic gaps);
        int hs;
        int k;
        int bad;
        hs  = 0;
        k   = 0;
        bad = 0;
        while (hs < 16 && k < 100) begin
            if (w_ready !== 1'b1 || arr_valid_w !== 16'h0 || busy !== 1'b1) bad++;
            w_valid = gaps ? (k % 2 == 0) : 1'b1;
            w_data  = w_valid ? w[hs] : 8'hA5;
            start   = gaps && (k == 6);
            if (w_valid && w_ready) hs++;
            step();
            k++;
        end
        w_valid = 1'b0;
        w_data  = 8'h00;
        start   = 1'b0;
        chk("load_handshakes", hs, 16);
        chk("load_cycles", k, gaps ? 31 : 16);
        chk("load_ready_held", bad, 0);
        chk("commit_valid_w", arr_valid_w, 16'hFFFF);
        chk("commit_w_ready", {w_ready, x_ready}, 2'b00);
        chk("commit_weights", arr_weight, w);
        step();
        chk("post_commit_valid_w", arr_valid_w, 16'h0);
        chk("post_commit_x_ready", x_ready, 1'b1);
    endtask

    task automatic stream(input int base, input int n);
        vec_t v;
        int   e;
        logic [COL-1:0][X_WIDTH-1:0] xe;
        logic [COL-1:0]              ve;
        for (int c = 0; c < n + LAT; c++) begin
            if (c >= LAT) begin
                v = tab[base + c - LAT];
                chk($sformatf("y_valid[%0d]", base + c - LAT), y_valid, v.valid);
                chk($sformatf("y_last[%0d]", base + c - LAT), y_last, v.valid & v.last);
                chk($sformatf("done[%0d]", base + c - LAT), done, v.valid & v.last);
                chk($sformatf("y_data[%0d]", base + c - LAT), y_data, v.valid ? v.y : 80'b0);
            end else begin
                chk($sformatf("pipe_quiet[%0d]", base), {y_valid, y_last, done}, 3'b000);
            end
            for (int j = 0; j < COL; j++) begin
                e = c - 1 - j;
                if (e >= 0 && e < n && tab[base + e].valid) begin
                    xe[j] = tab[base + e].x[j];
                    ve[j] = 1'b1;
                end else begin
                    xe[j] = '0;
                    ve[j] = 1'b0;
                end
            end
            chk($sformatf("skew_x[%0d.%0d]", base, c), arr_x, xe);
            chk($sformatf("skew_v[%0d.%0d]", base, c), arr_valid, ve);
            chk($sformatf("x_ready[%0d.%0d]", base, c), x_ready, c < n);
            if (c < n) begin
                x_valid = tab[base + c].valid;
                x_last  = tab[base + c].last;
                x_data  = tab[base + c].x;
            end else begin
                x_valid = 1'b0;
                x_last  = 1'b0;
                x_data  = '0;
            end
            step();
        end
        chk($sformatf("job_end_idle[%0d]", base), {busy, done, y_valid}, 3'b000);
    endtask

    initial begin
        logic [15:0][7:0] w_id;
        logic [15:0][7:0] w_inc;
        logic [15:0][7:0] w_sat;

        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        reuse_w  = 1'b0;
        w_data   = '0;
        w_valid  = 1'b0;
        x_data   = '0;
        x_valid  = 1'b0;
        x_last   = 1'b0;

        for (int k = 0; k < 16; k++) begin
            w_id[k]  = (k % 5 == 0) ? 8'd1 : 8'd0;
            w_inc[k] = 8'(k + 1);
            w_sat[k] = 8'd255;
        end

        tab[0] = mk(1'b1, 1'b1,   1, 2, 3, 4,      1, 2, 3, 4);
        tab[1] = mk(1'b1, 1'b0,   1, 1, 1, 1,     10, 26, 42, 58);
        tab[2] = mk(1'b1, 1'b0,   1, 0, 0, 0,      1, 5, 9, 13);
        tab[3] = mk(1'b1, 1'b1,   0, 0, 0, 2,      8, 16, 24, 32);
        tab[4] = mk(1'b1, 1'b0,   1, 1, 1, 1,     10, 26, 42, 58);
        tab[5] = mk(1'b0, 1'b0,   9, 9, 9, 9,      0, 0, 0, 0);
        tab[6] = mk(1'b0, 1'b0,   9, 9, 9, 9,      0, 0, 0, 0);
        tab[7] = mk(1'b1, 1'b1,   1, 0, 0, 0,      1, 5, 9, 13);
        tab[8] = mk(1'b1, 1'b1, 255, 255, 255, 255, 260100, 260100, 260100, 260100);
        tab[9] = mk(1'b1, 1'b1, 255, 255, 255, 255, 260100, 260100, 260100, 260100);

        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle_after_reset", {busy, w_ready, x_ready}, 3'b000);

        // Identity weights, one vector with last.
        start_job(1'b0);
        load_w(w_id, 1'b0);
        stream(0, 1);

        // Row-major 1..16 with weight stalls and a start pulse mid-load.
        start_job(1'b0);
        load_w(w_inc, 1'b1);
        stream(1, 3);

        // Same weights reused, with two bubbles between vectors.
        start_job(1'b1);
        stream(4, 4);

        // Saturating weights and data, then reuse.
        start_job(1'b0);
        load_w(w_sat, 1'b0);
        stream(8, 1);
        start_job(1'b1);
        stream(9, 1);

        // Reset three cycles after a vector handshake.
        start_job(1'b1);
        x_valid = 1'b1;
        x_last  = 1'b1;
        x_data  = tab[8].x;
        step();
        x_valid = 1'b0;
        x_last  = 1'b0;
        x_data  = '0;
        step();
        step();
        rst = 1'b1;
        step();
        chk_all_zero("midjob_reset");
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk($sformatf("post_reset_quiet[%0d]", c), {y_valid, y_last, done, busy}, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
